// File: rtl/debounce_multi.sv
// N-channel key debouncer: per-channel 2-FF synchroniser, stability FSM and saturating counter.
// Define DEBOUNCE_LONG_PRESS_EN to add the one-shot long-press pulse on key_long.
module debounce_multi #(
    parameter int N           = 4,
    parameter int DB_CYCLES   = 4_000_000,
    parameter int LONG_CYCLES = 200_000_000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key,
    output logic [N-1:0] key_level,
    output logic [N-1:0] key_press,
    output logic [N-1:0] key_release,
    output logic [N-1:0] key_long
);

    function automatic int bits_for(input int v);
        int n;
        int t;
        n = 0;
        t = v;
        while (t > 0) begin
            n++;
            t = t >> 1;
        end
        return (n < 1) ? 1 : n;
    endfunction

    localparam int MAX_CYCLES = (DB_CYCLES > LONG_CYCLES) ? DB_CYCLES : LONG_CYCLES;
    localparam int CW         = bits_for(MAX_CYCLES);

    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYCLES);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W_HI = 2'd1,
        HELD = 2'd2,
        W_LO = 2'd3
    } state_t;

    logic [N-1:0] inv_mask;
    logic [N-1:0] s1;
    logic [N-1:0] s2;

    assign inv_mask = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    // Polarity is normalised before the first flop so the FSM only ever sees "1 = pressed".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= key ^ inv_mask;
            s2 <= s1;
        end
    end

    for (genvar ch = 0; ch < N; ch++) begin : g_ch
        state_t        state;
        logic [CW-1:0] cnt;
        logic          level_r;
        logic          press_r;
        logic          release_r;
        logic          long_r;

        // One FSM per channel; pulses default low so each lasts exactly one cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state     <= IDLE;
                cnt       <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
            end else begin
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
                case (state)
                    IDLE: begin
                        if (s2[ch]) begin
                            state <= W_HI;
                            cnt   <= CW'(1);
                        end
                    end
                    W_HI: begin
                        if (!s2[ch]) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == DB_LAST) begin
                            state   <= HELD;
                            press_r <= 1'b1;
                            level_r <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    HELD: begin
                        if (!s2[ch]) begin
                            state <= W_LO;
                            cnt   <= CW'(1);
                        end
`ifdef DEBOUNCE_LONG_PRESS_EN
                        // Counter parks at LONG_CYCLES so the pulse cannot repeat during one press.
                        else if (cnt == LONG_LAST) begin
                            long_r <= 1'b1;
                            cnt    <= LONG_SAT;
                        end else if (cnt != LONG_SAT) begin
                            cnt <= cnt + CW'(1);
                        end
`endif
                    end
                    W_LO: begin
                        if (s2[ch]) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == DB_LAST) begin
                            state     <= IDLE;
                            release_r <= 1'b1;
                            level_r   <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign key_level[ch]   = level_r;
        assign key_press[ch]   = press_r;
        assign key_release[ch] = release_r;
`ifdef DEBOUNCE_LONG_PRESS_EN
        assign key_long[ch]    = long_r;
`else
        assign key_long[ch]    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: vector table plus hand-timed corner sequences.
// Expected long-press results follow DEBOUNCE_LONG_PRESS_EN.
module tb_debounce_multi;

    localparam int N    = 4;
    localparam int DB   = 8;
    localparam int LONG = 32;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [3:0] LONG_EXP   = 4'b0001;
    localparam int         LONG_COUNT = 1;
    localparam int         LONG_TICK  = 42;
`else
    localparam logic [3:0] LONG_EXP   = 4'b0000;
    localparam int         LONG_COUNT = 0;
    localparam int         LONG_TICK  = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_al;
    logic [3:0] key;
    logic [3:0] key_al;
    logic [3:0] level, press, rel, lng;
    logic [3:0] level_al, press_al, rel_al, lng_al;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0] key;
        int         hold;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] level;
    } vec_t;

    vec_t vecs[$];

    debounce_multi #(.N(N), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .key(key),
        .key_level(level), .key_press(press), .key_release(rel), .key_long(lng)
    );

    debounce_multi #(.N(N), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst(rst_al), .key(key_al),
        .key_level(level_al), .key_press(press_al), .key_release(rel_al), .key_long(lng_al)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives k for hold cycles and returns the OR of every pulse seen plus any press/release overlap.
    task automatic applyStimulus(input logic [3:0] k, input int hold,
                                 output logic [3:0] pm, output logic [3:0] rm,
                                 output logic [3:0] lm, output logic [3:0] om);
        key = k;
        pm = '0; rm = '0; lm = '0; om = '0;
        for (int i = 0; i < hold; i++) begin
            tick();
            pm |= press;
            rm |= rel;
            lm |= lng;
            om |= press & rel;
        end
    endtask

    function automatic vec_t mk(input logic [3:0] k, input int h, input logic [3:0] p,
                                input logic [3:0] r, input logic [3:0] l, input logic [3:0] lv);
        vec_t v;
        v.key = k; v.hold = h; v.press = p; v.rel = r; v.lng = l; v.level = lv;
        return v;
    endfunction

    initial begin
        logic [3:0] pm, rm, lm, om;
        int first, count;

        vecs.push_back(mk(4'b0001, 12, 4'b0001, 4'b0000, 4'b0000, 4'b0001));
        vecs.push_back(mk(4'b0000, 12, 4'b0000, 4'b0001, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0010,  5, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0000,  2, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0010,  7, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0010, 12, 4'b0010, 4'b0000, 4'b0000, 4'b0010));
        vecs.push_back(mk(4'b0000, 12, 4'b0000, 4'b0010, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b1100, 20, 4'b1100, 4'b0000, 4'b0000, 4'b1100));
        vecs.push_back(mk(4'b0100, 12, 4'b0000, 4'b1000, 4'b0000, 4'b0100));
        vecs.push_back(mk(4'b0000, 12, 4'b0000, 4'b0100, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0001, 60, 4'b0001, 4'b0000, LONG_EXP, 4'b0001));
        vecs.push_back(mk(4'b0000, 12, 4'b0000, 4'b0001, 4'b0000, 4'b0000));

        rst    = 1'b1;
        rst_al = 1'b1;
        key    = 4'hF;
        key_al = 4'hF;

        // Reset with all keys held, then the full-latency press on every channel.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("reset_level", level, 4'h0);
            checkOutput("reset_pulses", press | rel | lng, 4'h0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i <= 9)  checkOutput("rst_release_no_press", press, 4'h0);
            if (i == 10) checkOutput("rst_release_press", press, 4'hF);
            if (i == 10) checkOutput("rst_release_level", level, 4'hF);
            if (i == 11) checkOutput("rst_release_press_width", press, 4'h0);
        end
        key = 4'h0;
        repeat (15) tick();
        checkOutput("all_released_level", level, 4'h0);

        // Exact press/release latency on channel 0.
        key = 4'b0001;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 9)  checkOutput("press0_early", press | level, 4'h0);
            if (i == 10) checkOutput("press0_edge", press, 4'b0001);
            if (i == 10) checkOutput("press0_level", level, 4'b0001);
            if (i == 11) checkOutput("press0_width", press, 4'h0);
        end
        key = 4'b0000;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 9)  checkOutput("release0_early", rel, 4'h0);
            if (i == 9)  checkOutput("release0_level_held", level, 4'b0001);
            if (i == 10) checkOutput("release0_edge", rel, 4'b0001);
            if (i == 10) checkOutput("release0_level", level, 4'h0);
            if (i == 11) checkOutput("release0_width", rel, 4'h0);
        end

        // Bounce on channel 1, then exact timing from the final rising sample.
        applyStimulus(4'b0010, 5, pm, rm, lm, om);
        checkOutput("bounce_a", pm | rm | level, 4'h0);
        applyStimulus(4'b0000, 2, pm, rm, lm, om);
        checkOutput("bounce_b", pm | rm | level, 4'h0);
        applyStimulus(4'b0010, 7, pm, rm, lm, om);
        checkOutput("bounce_c", pm | rm | level, 4'h0);
        applyStimulus(4'b0000, 1, pm, rm, lm, om);
        checkOutput("bounce_d", pm | rm | level, 4'h0);
        key = 4'b0010;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i <= 9)  checkOutput("bounce_final_no_press", press, 4'h0);
            if (i == 10) checkOutput("bounce_final_press", press, 4'b0010);
        end
        key = 4'b0000;
        repeat (12) tick();

        for (int v = 0; v < vecs.size(); v++) begin
            applyStimulus(vecs[v].key, vecs[v].hold, pm, rm, lm, om);
            checkOutput($sformatf("vec%0d_press", v), pm, vecs[v].press);
            checkOutput($sformatf("vec%0d_release", v), rm, vecs[v].rel);
            checkOutput($sformatf("vec%0d_long", v), lm, vecs[v].lng);
            checkOutput($sformatf("vec%0d_level", v), level, vecs[v].level);
            checkOutput($sformatf("vec%0d_overlap", v), om, 4'h0);
        end

        // Long-press timing on channel 0.
        key   = 4'b0001;
        first = 0;
        count = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (lng[0]) begin
                count++;
                if (first == 0) first = i;
            end
            if (lng[3:1] != 3'b000) count++;
        end
        checkCount("long_pulse_count", count, LONG_COUNT);
        checkCount("long_pulse_tick", first, LONG_TICK);
        key = 4'b0000;
        repeat (12) tick();

        // Active-low instance: press, release, then reset during W_HI.
        rst_al = 1'b0;
        repeat (5) tick();
        checkOutput("al_idle_level", level_al, 4'h0);
        key_al = 4'b1101;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 9)  checkOutput("al_press_early", press_al, 4'h0);
            if (i == 10) checkOutput("al_press_edge", press_al, 4'b0010);
            if (i == 10) checkOutput("al_press_level", level_al, 4'b0010);
        end
        key_al = 4'hF;
        repeat (12) tick();
        checkOutput("al_release_level", level_al, 4'h0);

        key_al = 4'b1101;
        count  = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (press_al != 4'h0) count++;
        end
        rst_al = 1'b1;
        repeat (2) tick();
        checkCount("al_no_pulse_before_reset", count, 0);
        checkOutput("al_reset_outputs", level_al | press_al | rel_al, 4'h0);
        rst_al = 1'b0;
        first  = 0;
        count  = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (press_al != 4'h0) begin
                count++;
                if (first == 0) first = i;
            end
        end
        checkCount("al_repress_tick", first, 10);
        checkCount("al_repress_count", count, 1);
        checkOutput("al_repress_level", level_al, 4'b0010);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
